truth_table_sweeper: RTL and testbench
======================================

# truth_table_sweeper

Parametrised, registered truth-table engine for N_IN-input, N_OUT-output Boolean functions. Each function is stored as a programmable table; the block sweeps every input combination in binary or Gray order and streams each (inputs, outputs) row through a valid/ready handshake. While sweeping it counts the maxterms (zero rows) of every output channel. It replaces hand-written fixed expressions plus testbench sweeps: the table is loaded once, swept in hardware, and the per-channel zero counts are checked at the end.

## Interface
Parameters:
- N_IN, default 4: number of function inputs; the table depth is 2^N_IN rows. Legal range 1..8.
- N_OUT, default 3: number of output functions (channels), one table column each.

Ports:
- clk  in  1  clock; everything updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- wr_en  in  1  table row write strobe.
- wr_addr  in  N_IN  row index to write.
- wr_data  in  N_OUT  row value; bit k is channel k.
- start  in  1  begin a sweep.
- mode  in  1  sweep order, sampled when start is accepted: 0 = binary, 1 = Gray.
- busy  out  1  high while a sweep is in progress.
- out_valid  out  1  a stream row is presented.
- out_ready  in  1  the consumer accepts the row.
- out_in  out  N_IN  input combination of the current row.
- out_f  out  N_OUT  table value at out_in.
- done  out  1  one-cycle pulse when a sweep completes.
- zero_cnt  out  N_OUT*(N_IN+1)  per-channel zero count; channel k occupies bits [k*(N_IN+1) +: N_IN+1].

## Operation
- Storage: 2^N_IN rows × N_OUT bits.
  - On reset every row is set to all ones (no maxterms).
- Table write:
  - When wr_en=1 and the FSM is in IDLE, row[wr_addr] <= wr_data.
  - Writes in SWEEP or DONE are ignored.
- FSM states: IDLE, SWEEP, DONE.
- IDLE:
  - start=1 → go to SWEEP; idx <= 0; latch mode; clear zero_cnt.
  - If wr_en and start are both high, the write takes effect and the sweep starts. The write completes before row 0 is read.
- SWEEP:
  - Outputs: out_valid=1; out_in = idx in binary mode, or idx ^ (idx>>1) in Gray mode; out_f = row[out_in].
  - On out_valid & out_ready: every channel k with out_f[k]=0 increments its zero_cnt field.
  - If idx = 2^N_IN−1 → go to DONE; otherwise idx <= idx+1.
  - Without out_ready the row holds stable: out_in and out_f do not change.
- DONE: done=1 for exactly one cycle, then → IDLE.
- start is ignored in SWEEP and DONE.
- zero_cnt holds its final value until the next accepted start.
  - Width N_IN+1, so an all-zero channel reads exactly 2^N_IN with no wrap.
- Reset mid-sweep: the sweep aborts, the FSM returns to IDLE, the table is restored to all ones, and all outputs return to reset values.

## Timing
- Reset values: busy=0, out_valid=0, out_in=0, out_f=0, done=0, zero_cnt=0.
- busy=1 in SWEEP and DONE.
- The start-accept edge enters SWEEP. out_valid rises in the following cycle with row 0.
- out_in/out_f are registered. With out_ready held at 1, one row transfers per cycle: a full sweep takes 2^N_IN cycles of out_valid.
- The cycle after the last handshake is DONE (done=1). The zero counts are final in that cycle.
- Minimum start-to-done time is 2^N_IN+1 cycles. A new start can be accepted in the cycle after DONE.
- A write lands on the clock edge and is visible to any sweep started in a later cycle.

## Test plan
- Reset/defaults: assert reset for 2 cycles → all outputs 0. A binary sweep with out_ready=1 gives out_f=3'b111 for rows 0..15, done after 17 cycles, zero_cnt all 0.
- Load and count (N_IN=4, N_OUT=3): write row 0=3'b000 and row 5=3'b010; binary sweep → out_f=3'b010 at out_in=5; zero counts ch0=2, ch1=1, ch2=2.
- Gray order: mode=1 → out_in sequence 0,1,3,2,6,7,5,4,12,… ending at 8; zero counts identical to binary mode.
- Backpressure: toggle out_ready pseudo-randomly → out_in/out_f stable while ready=0; exactly 16 handshakes; zero counts unchanged from the stall-free run.
- Ignored controls: wr_en to row 5 and start asserted mid-sweep → no table change, no restart; a following sweep still shows row 5 as 3'b010.
- Reset mid-sweep: reset at row 7 → busy=0, zero_cnt=0, table all ones; the next sweep yields 16 rows of 3'b111.

Source files
------------

// File: rtl/truth_table_sweeper.sv
// Programmable N_IN-input / N_OUT-output truth table that sweeps every input
// combination (binary or Gray order) over a valid/ready stream and counts zeros per channel.
module truth_table_sweeper #(
    parameter int N_IN  = 4,
    parameter int N_OUT = 3
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      wr_en,
    input  logic [N_IN-1:0]           wr_addr,
    input  logic [N_OUT-1:0]          wr_data,
    input  logic                      start,
    input  logic                      mode,
    output logic                      busy,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [N_IN-1:0]           out_in,
    output logic [N_OUT-1:0]          out_f,
    output logic                      done,
    output logic [N_OUT*(N_IN+1)-1:0] zero_cnt
);

    localparam int DEPTH = 1 << N_IN;
    localparam int CW    = N_IN + 1;
    localparam logic [N_IN-1:0] LAST_IDX = '1;

    typedef enum logic [1:0] {
        IDLE,
        SWEEP,
        DONE
    } state_t;

    state_t           state;
    logic [N_IN-1:0]  idx;
    logic             gray_q;
    logic [N_OUT-1:0] tbl [DEPTH];

    logic [N_IN-1:0]  idx_next;
    logic [N_IN-1:0]  in_next;
    logic [N_OUT-1:0] row0;

    // NOTE: every always_comb output gets a value on every path, so no latch is inferred.
    always_comb begin
        idx_next = idx + N_IN'(1);
        in_next  = gray_q ? (idx_next ^ (idx_next >> 1)) : idx_next;
        // A write issued together with start must already be visible in row 0.
        row0     = (wr_en && wr_addr == '0) ? wr_data : tbl[0];
    end

    // NOTE: the table is reset on purpose (all ones = no maxterms); this costs a
    // reset mux per bit, so keep the depth small or drop the reset for large tables.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int r = 0; r < DEPTH; r++) begin
                tbl[r] <= '1;
            end
        end else if (wr_en && state == IDLE) begin
            tbl[wr_addr] <= wr_data;
        end
    end

    // NOTE: all sequential state uses non-blocking assignments so every register
    // samples pre-edge values and block ordering cannot change behaviour.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            idx       <= '0;
            gray_q    <= 1'b0;
            busy      <= 1'b0;
            out_valid <= 1'b0;
            out_in    <= '0;
            out_f     <= '0;
            done      <= 1'b0;
            zero_cnt  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state     <= SWEEP;
                        idx       <= '0;
                        gray_q    <= mode;
                        busy      <= 1'b1;
                        out_valid <= 1'b1;
                        out_in    <= '0;
                        out_f     <= row0;
                        zero_cnt  <= '0;
                    end
                end
                SWEEP: begin
                    // out_valid is always high here, so out_ready alone completes a handshake.
                    if (out_ready) begin
                        for (int k = 0; k < N_OUT; k++) begin
                            if (!out_f[k]) begin
                                zero_cnt[k*CW +: CW] <= zero_cnt[k*CW +: CW] + CW'(1);
                            end
                        end
                        if (idx == LAST_IDX) begin
                            state     <= DONE;
                            out_valid <= 1'b0;
                            done      <= 1'b1;
                        end else begin
                            idx    <= idx_next;
                            out_in <= in_next;
                            out_f  <= tbl[in_next];
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                    done  <= 1'b0;
                    busy  <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Self-checking bench for truth_table_sweeper (N_IN=4, N_OUT=3): vector table,
// randomized writes/backpressure against a row-array reference model, and corner sequences.
module tb_truth_table_sweeper;

    logic        clk = 1'b0;
    logic        reset;
    logic        wr_en;
    logic [3:0]  wr_addr;
    logic [2:0]  wr_data;
    logic        start;
    logic        mode;
    logic        busy;
    logic        out_valid;
    logic        out_ready;
    logic [3:0]  out_in;
    logic [2:0]  out_f;
    logic        done;
    logic [14:0] zero_cnt;

    int n_checks = 0;
    int n_pass   = 0;

    logic [2:0] model_tbl [16];

    truth_table_sweeper #(.N_IN(4), .N_OUT(3)) dut (
        .clk       (clk),
        .reset     (reset),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .start     (start),
        .mode      (mode),
        .busy      (busy),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_in    (out_in),
        .out_f     (out_f),
        .done      (done),
        .zero_cnt  (zero_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end else begin
            n_pass++;
        end
    endtask

    function automatic logic [14:0] pack_z(input int z0, input int z1, input int z2);
        return {5'(z2), 5'(z1), 5'(z0)};
    endfunction

    // Zero count per channel is simply how many table rows hold a 0 in that column.
    function automatic logic [14:0] exp_zero();
        int z [3];
        for (int k = 0; k < 3; k++) begin
            z[k] = 0;
            for (int r = 0; r < 16; r++) begin
                if (!model_tbl[r][k]) z[k]++;
            end
        end
        return pack_z(z[0], z[1], z[2]);
    endfunction

    task automatic model_reset();
        for (int r = 0; r < 16; r++) model_tbl[r] = 3'b111;
    endtask

    task automatic write_row(input logic [3:0] a, input logic [2:0] d);
        wr_en = 1'b1; wr_addr = a; wr_data = d;
        model_tbl[a] = d;
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    // Runs one sweep from IDLE. Called and returns at a falling edge.
    task automatic sweep(input logic m, input int ready_pct, input int inject_at,
                         input bit ws_en, input logic [3:0] ws_addr, input logic [2:0] ws_data);
        int         n, cyc;
        bit         seen_done, stalled;
        logic [3:0] held_in, exp_in;
        logic [2:0] held_f;
        start = 1'b1; mode = m; out_ready = 1'b0;
        wr_en = ws_en; wr_addr = ws_addr; wr_data = ws_data;
        if (ws_en) model_tbl[ws_addr] = ws_data;
        n = 0; cyc = 0; seen_done = 0; stalled = 0;
        held_in = '0; held_f = '0;
        while (!seen_done && cyc < 400) begin
            @(negedge clk);
            cyc++;
            start = 1'b0; wr_en = 1'b0; mode = ~m;
            if (cyc == 1) check("busy_after_start", 32'(busy), 1);
            if (stalled) begin
                check("stall_in_stable", 32'(out_in), 32'(held_in));
                check("stall_f_stable", 32'(out_f), 32'(held_f));
            end
            if (done) begin
                seen_done = 1;
                check("handshakes", n, 16);
                check("zero_cnt_final", 32'(zero_cnt), 32'(exp_zero()));
                check("busy_in_done", 32'(busy), 1);
                check("valid_in_done", 32'(out_valid), 0);
                if (ready_pct >= 100) check("start_to_done", cyc, 17);
            end else begin
                exp_in = m ? 4'(n ^ (n >> 1)) : 4'(n);
                check("valid_in_sweep", 32'(out_valid), 1);
                check("row_in", 32'(out_in), 32'(exp_in));
                check("row_f", 32'(out_f), 32'(model_tbl[exp_in]));
                if (cyc == inject_at) begin
                    start = 1'b1; wr_en = 1'b1; wr_addr = 4'd5; wr_data = 3'b101;
                end
                out_ready = ($urandom_range(99) < ready_pct);
                stalled   = !out_ready;
                held_in   = out_in;
                held_f    = out_f;
                if (out_ready) n++;
            end
        end
        out_ready = 1'b0;
        if (!seen_done) check("done_timeout", 0, 1);
        @(negedge clk);
        check("done_one_cycle", 32'(done), 0);
        check("busy_after_done", 32'(busy), 0);
    endtask

    typedef struct {
        logic [3:0] addr;
        logic [2:0] data;
        logic       m;
        int         ready_pct;
        int         z0, z1, z2;
    } vec_t;

    initial begin
        vec_t vecs [5];
        int   cyc;

        // Writes accumulate; expected counts are hand-derived from the table contents.
        vecs[0] = '{4'd0,  3'b000, 1'b0, 100, 1, 1, 1};
        vecs[1] = '{4'd5,  3'b010, 1'b0, 100, 2, 1, 2};
        vecs[2] = '{4'd5,  3'b010, 1'b1, 50,  2, 1, 2};
        vecs[3] = '{4'd15, 3'b100, 1'b1, 100, 3, 2, 2};
        vecs[4] = '{4'd0,  3'b111, 1'b0, 60,  2, 1, 1};

        reset = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
        start = 1'b0; mode = 1'b0; out_ready = 1'b0;
        model_reset();

        repeat (2) @(negedge clk);
        reset = 1'b0;
        check("rst_busy", 32'(busy), 0);
        check("rst_valid", 32'(out_valid), 0);
        check("rst_in", 32'(out_in), 0);
        check("rst_f", 32'(out_f), 0);
        check("rst_done", 32'(done), 0);
        check("rst_zero_cnt", 32'(zero_cnt), 0);

        // Default table: every row 3'b111, no zeros.
        sweep(1'b0, 100, -1, 1'b0, 4'd0, 3'b000);
        check("default_zero_cnt", 32'(zero_cnt), 0);

        foreach (vecs[i]) begin
            write_row(vecs[i].addr, vecs[i].data);
            sweep(vecs[i].m, vecs[i].ready_pct, -1, 1'b0, 4'd0, 3'b000);
            check("vec_zero_cnt", 32'(zero_cnt), 32'(pack_z(vecs[i].z0, vecs[i].z1, vecs[i].z2)));
        end

        // Write and start attempted mid-sweep must neither land nor restart.
        sweep(1'b0, 100, 6, 1'b0, 4'd0, 3'b000);
        sweep(1'b1, 100, -1, 1'b0, 4'd0, 3'b000);
        check("ignored_write_zero_cnt", 32'(zero_cnt), 32'(pack_z(2, 1, 1)));

        // Write coinciding with start is visible in row 0 of that sweep.
        sweep(1'b0, 100, -1, 1'b1, 4'd0, 3'b011);
        check("write_with_start_zero_cnt", 32'(zero_cnt), 32'(pack_z(2, 1, 2)));

        for (int it = 0; it < 8; it++) begin
            int nw = $urandom_range(3);
            for (int w = 0; w < nw; w++) begin
                write_row(4'($urandom_range(15)), 3'($urandom_range(7)));
            end
            sweep(1'($urandom_range(1)), $urandom_range(30, 100), -1, 1'b0, 4'd0, 3'b000);
        end

        // Reset at row 7 aborts the sweep and restores the all-ones table.
        write_row(4'd2, 3'b000);
        start = 1'b1; mode = 1'b0; out_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc = 0;
        while (out_in != 4'd7 && cyc < 40) begin
            @(negedge clk);
            cyc++;
        end
        check("reach_row7", 32'(out_in), 7);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0; out_ready = 1'b0;
        model_reset();
        check("midrst_busy", 32'(busy), 0);
        check("midrst_valid", 32'(out_valid), 0);
        check("midrst_in", 32'(out_in), 0);
        check("midrst_f", 32'(out_f), 0);
        check("midrst_done", 32'(done), 0);
        check("midrst_zero_cnt", 32'(zero_cnt), 0);
        @(negedge clk);
        check("midrst_no_restart", 32'(busy), 0);
        sweep(1'b0, 100, -1, 1'b0, 4'd0, 3'b000);
        check("after_rst_zero_cnt", 32'(zero_cnt), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
